// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: segment bit positions,
// scan FSM encoding and default scan timing.
package display_pkg;

  localparam int SEG_A   = 0;
  localparam int SEG_B   = 1;
  localparam int SEG_C   = 2;
  localparam int SEG_D   = 3;
  localparam int SEG_E   = 4;
  localparam int SEG_F   = 5;
  localparam int SEG_G   = 6;
  localparam int SEG_DOT = 7;

  // Segments a..g; the dot is sourced from the per-digit mask instead of the decoder.
  localparam logic [7:0] SEG_LED_MASK = 8'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                           (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                           (1 << SEG_G));

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam int DEFAULT_SCAN_DIV     = 50000;
  localparam int DEFAULT_BLANK_CYCLES = 500;

endpackage

// File: rtl/display_scan_controller_if.sv
// Bundle between the system side (state codes, decoder) and the scan controller.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic [2*NUM_DIGITS-1:0]   digit_states;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [1:0]                state_sel;
  logic [7:0]                seg_in;
  logic [7:0]                seg_out;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic                      frame_tick;

  modport master (
    output enable, digit_states, dp_mask, seg_in,
    input  state_sel, seg_out, digit_en, frame_tick
  );

  modport slave (
    input  enable, digit_states, dp_mask, seg_in,
    output state_sel, seg_out, digit_en, frame_tick
  );
endinterface

// File: rtl/scan_prescaler.sv
// Per-slot cycle counter; strobes when the blanking part and the whole slot end.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = DEFAULT_SCAN_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  localparam int CNT_W       = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             blank_done,
  output logic             slot_done
);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign blank_done = (cnt_q == BLANK_LAST);
  assign slot_done  = (cnt_q == SLOT_LAST);
  assign cnt        = cnt_q;

  // NOTE: give every always_comb target a default first so no path leaves it unassigned (latch).
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run || slot_done) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS seven-segment digits through one shared decoder, with a dark
// gap at the start of every slot and a per-frame snapshot of the digit codes.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = DEFAULT_SCAN_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input logic                      clk,
  input logic                      rst_n,
  display_scan_controller_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [2*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;

  logic [CNT_W-1:0] cnt;
  logic             blank_done;
  logic             slot_done;
  logic             run;

  // Counter restarts at 0 on entry to BLANK from IDLE and whenever scanning stops.
  assign run = bus.enable && (state_q != IDLE);

  scan_prescaler #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .cnt        (cnt),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          idx_d     = '0;
          snap_d    = bus.digit_states;
          dp_snap_d = bus.dp_mask;
        end
        BLANK: if (blank_done) state_d = SHOW;
        SHOW: if (slot_done) begin
          state_d = BLANK;
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            snap_d    = bus.digit_states;
            dp_snap_d = bus.dp_mask;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      dp_snap_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
    end
  end

  // Outputs decode registered state only; seg_in is the single combinational path.
  always_comb begin
    bus.state_sel = 2'b00;
    bus.digit_en  = '0;
    bus.seg_out   = 8'h00;
    if (state_q != IDLE) bus.state_sel = snap_q[2*idx_q +: 2];
    if (state_q == SHOW) begin
      bus.digit_en = NUM_DIGITS'(1) << idx_q;
      bus.seg_out  = (bus.seg_in & SEG_LED_MASK) | (8'(dp_snap_q[idx_q]) << SEG_DOT);
    end
  end

  assign bus.frame_tick = (state_q == SHOW) && slot_done && (idx_q == LAST_IDX);

  logic unused_cnt;
  assign unused_cnt = ^cnt;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller; a frame-position model feeds a
// scoreboard queue that is checked against the DUT one step after each edge.
module tb_display_scan_controller;
  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  typedef struct packed {
    logic [3:0] digit_en;
    logic [1:0] state_sel;
    logic [7:0] seg_out;
    logic       frame_tick;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_controller #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  bit         m_on   = 1'b0;
  int         m_k    = 0;
  logic [7:0] m_snap = '0;
  logic [3:0] m_dp   = '0;
  int         cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected outputs derived from position inside the frame, not from FSM state.
  function automatic exp_t model_out();
    exp_t e;
    int   pos, d, ph;
    e = '0;
    if (m_on) begin
      pos          = m_k % FRAME;
      d            = pos / SD;
      ph           = pos % SD;
      e.state_sel  = m_snap[2*d +: 2];
      e.frame_tick = (pos == FRAME - 1);
      if (ph >= BC) begin
        e.digit_en = 4'(1 << d);
        e.seg_out  = {m_dp[d], bus.seg_in[6:0]};
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (!rst_n) m_on = 1'b0;
    else if (!m_on) begin
      if (bus.enable) begin
        m_on   = 1'b1;
        m_k    = 0;
        m_snap = bus.digit_states;
        m_dp   = bus.dp_mask;
      end
    end else if (!bus.enable) m_on = 1'b0;
    else begin
      m_k++;
      if (m_k % FRAME == 0) begin
        m_snap = bus.digit_states;
        m_dp   = bus.dp_mask;
      end
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".digit_en"},   32'(bus.digit_en),   32'(e.digit_en));
      check({tag, ".state_sel"},  32'(bus.state_sel),  32'(e.state_sel));
      check({tag, ".seg_out"},    32'(bus.seg_out),    32'(e.seg_out));
      check({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'(e.frame_tick));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    sb.push_back(model_out());
    cyc++;
    #1;
    compare_out(tag);
  endtask

  initial begin
    int ticks;
    int last_tick;

    bus.enable       = 1'b0;
    bus.digit_states = 8'b11_10_01_00;
    bus.dp_mask      = 4'b0100;
    bus.seg_in       = 8'hFF;

    #1;
    sb.push_back('0);
    #1;
    compare_out("reset");
    repeat (2) step("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step("idle");

    bus.enable = 1'b1;
    repeat (40) step("scan");

    bus.seg_in = 8'h5B;
    repeat (8) step("seg_5b");
    bus.seg_in = 8'h86;
    repeat (8) step("seg_86");
    bus.seg_in = 8'hFF;

    // New codes mid-frame must stay invisible until the frame boundary.
    bus.digit_states = 8'hFF;
    bus.dp_mask      = 4'b1001;
    repeat (FRAME) step("no_tear");

    ticks     = 0;
    last_tick = -1;
    repeat (3 * FRAME) begin
      step("frame");
      if (bus.frame_tick === 1'b1) begin
        if (last_tick >= 0) check("tick_spacing", 32'(cyc - last_tick), 32'(FRAME));
        last_tick = cyc;
        ticks++;
      end
    end
    check("tick_count", 32'(ticks), 32'd3);

    bus.digit_states = 8'b00_01_10_11;
    bus.dp_mask      = 4'b0010;
    for (int i = 0; i < 2 * FRAME && !(m_on && (m_k % FRAME) == 2*SD + 3); i++) step("seek_d2");
    check("seek_d2_show", 32'(bus.digit_en), 32'b0100);
    bus.enable = 1'b0;
    repeat (3) step("disabled");
    bus.enable = 1'b1;
    repeat (12) step("reenable");

    for (int i = 0; i < 2 * FRAME && !(m_on && (m_k % FRAME) == FRAME - 1); i++) step("seek_end");
    check("seek_end_tick", 32'(bus.frame_tick), 32'd1);
    bus.enable       = 1'b0;
    bus.digit_states = 8'h1B;
    repeat (2) step("end_drop");
    bus.enable = 1'b1;
    repeat (FRAME + 4) step("after_drop");

    for (int i = 0; i < 2 * SD && !(m_on && (m_k % SD) == 4); i++) step("seek_show");
    check("seek_show_lit", 32'(bus.digit_en != 4'b0000), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    m_on  = 1'b0;
    #1;
    sb.push_back('0);
    compare_out("async_rst");
    #1;
    rst_n = 1'b1;
    repeat (12) step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
